ps2_key_encoder: RTL and testbench

Receives the raw PS/2 keyboard serial stream (ps2_clk/ps2_data) and produces the 11-bit toggle-event `ps2_key` word that the core's keyboard decoders consume. It is the producing end of that interface. It deframes PS/2 bytes and tracks `E0`, `F0` and `E1` prefixes. It then publishes one event per key make/break by flipping bit 10. The block sits between the user-port/PS2 pins and the per-game input mapping in `emu`, and is used when no HPS is supplying `ps2_key`.

---
 rtl/ps2_key_encoder.sv | 263 ++++++++++++++++++++++++++
 tb/tb_ps2_key_encoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard deframer and prefix decoder producing the 11-bit toggle-event ps2_key word.
// Optional macro PS2_KEY_TYPEMATIC_FILTER_EN suppresses repeated makes of the held key.
module ps2_key_encoder #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 80000
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        parity_err,
    output logic        frame_err
);

    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_E0   = 3'd1,
        S_F0   = 3'd2,
        S_E0F0 = 3'd3,
        S_E1   = 3'd4
    } state_t;

    // Odd parity across data and parity bit.
    function automatic logic parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    // Controller responses and fill bytes that never form a key event.
    function automatic logic is_discard(input logic [7:0] b);
        logic r;
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: r = 1'b1;
            default:                                 r = 1'b0;
        endcase
        return r;
    endfunction

    // Bit 0 carries ps2_clk, bit 1 carries ps2_data.
    logic [1:0]       sync1_r;
    logic [1:0]       sync2_r;
    logic [1:0]       filt_r;
    logic [FLT_W-1:0] flt_cnt_r [2];
    logic             clk_filt_d_r;
    logic             fall_s;
    logic             data_bit_s;

    logic [3:0]       bit_cnt_r;
    logic [7:0]       shift_r;
    logic             par_r;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic             byte_valid_r;

    state_t           state_r;
    state_t           state_nx_s;
    logic [2:0]       skip_r;
    logic [2:0]       skip_nx_s;
    logic             emit_s;
    logic             pressed_s;
    logic             ext_s;

    // Synchronize both pins and glitch-filter them; a level change needs FILTER_LEN agreeing samples.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            sync1_r      <= 2'b11;
            sync2_r      <= 2'b11;
            filt_r       <= 2'b11;
            clk_filt_d_r <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                flt_cnt_r[i] <= {FLT_W{1'b0}};
            end
        end else begin
            sync1_r      <= {ps2_data, ps2_clk};
            sync2_r      <= sync1_r;
            clk_filt_d_r <= filt_r[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == filt_r[i]) begin
                    flt_cnt_r[i] <= {FLT_W{1'b0}};
                end else if (flt_cnt_r[i] == FLT_W'(FILTER_LEN - 1)) begin
                    filt_r[i]    <= sync2_r[i];
                    flt_cnt_r[i] <= {FLT_W{1'b0}};
                end else begin
                    flt_cnt_r[i] <= flt_cnt_r[i] + FLT_W'(1);
                end
            end
        end
    end

    assign fall_s     = clk_filt_d_r & ~filt_r[0];
    assign data_bit_s = filt_r[1];

    // Deframer: bit counter, shift register, parity/stop checks and inter-edge timeout.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            bit_cnt_r    <= 4'd0;
            shift_r      <= 8'd0;
            par_r        <= 1'b0;
            tmo_cnt_r    <= {TMO_W{1'b0}};
            byte_valid_r <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            byte_valid_r <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            if (fall_s) begin
                tmo_cnt_r <= {TMO_W{1'b0}};
                case (bit_cnt_r)
                    4'd0: begin
                        if (data_bit_s) begin
                            frame_err <= 1'b1;
                        end else begin
                            bit_cnt_r <= 4'd1;
                        end
                    end
                    4'd9: begin
                        par_r     <= data_bit_s;
                        bit_cnt_r <= 4'd10;
                    end
                    4'd10: begin
                        bit_cnt_r <= 4'd0;
                        if (!data_bit_s) begin
                            frame_err <= 1'b1;
                        end else if (!parity_ok(shift_r, par_r)) begin
                            parity_err <= 1'b1;
                        end else begin
                            byte_valid_r <= 1'b1;
                        end
                    end
                    default: begin
                        shift_r   <= {data_bit_s, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                    end
                endcase
            end else if (bit_cnt_r == 4'd0) begin
                tmo_cnt_r <= {TMO_W{1'b0}};
            end else if (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1)) begin
                // An edge in this same cycle would have taken the branch above instead.
                tmo_cnt_r <= {TMO_W{1'b0}};
                bit_cnt_r <= 4'd0;
                frame_err <= 1'b1;
            end else begin
                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end
        end
    end

    // Prefix state register.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            state_r <= S_IDLE;
            skip_r  <= 3'd0;
        end else begin
            state_r <= state_nx_s;
            skip_r  <= skip_nx_s;
        end
    end

    // Prefix next-state and event decode; shift_r holds the completed byte while byte_valid_r is high.
    always_comb begin
        state_nx_s = state_r;
        skip_nx_s  = skip_r;
        emit_s     = 1'b0;
        pressed_s  = 1'b0;
        ext_s      = 1'b0;
        if (byte_valid_r) begin
            if (state_r == S_E1) begin
                skip_nx_s = skip_r - 3'd1;
                if (skip_r == 3'd1) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_E1;
                end
            end else if (is_discard(shift_r)) begin
                state_nx_s = S_IDLE;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        if (shift_r == 8'hE0) begin
                            state_nx_s = S_E0;
                        end else if (shift_r == 8'hF0) begin
                            state_nx_s = S_F0;
                        end else if (shift_r == 8'hE1) begin
                            state_nx_s = S_E1;
                            skip_nx_s  = 3'd7;
                        end else begin
                            emit_s     = 1'b1;
                            pressed_s  = 1'b1;
                            state_nx_s = S_IDLE;
                        end
                    end
                    S_E0: begin
                        if (shift_r == 8'hF0) begin
                            state_nx_s = S_E0F0;
                        end else begin
                            emit_s     = 1'b1;
                            pressed_s  = 1'b1;
                            ext_s      = 1'b1;
                            state_nx_s = S_IDLE;
                        end
                    end
                    S_F0: begin
                        emit_s     = 1'b1;
                        state_nx_s = S_IDLE;
                    end
                    S_E0F0: begin
                        emit_s     = 1'b1;
                        ext_s      = 1'b1;
                        state_nx_s = S_IDLE;
                    end
                    default: begin
                        state_nx_s = S_IDLE;
                    end
                endcase
            end
        end else begin
            state_nx_s = state_r;
        end
    end

`ifdef PS2_KEY_TYPEMATIC_FILTER_EN
    logic [8:0] held_r;
    logic       held_vld_r;

    // Publish events; a make matching the held key is a typematic repeat and is dropped.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            ps2_key    <= 11'd0;
            held_r     <= 9'd0;
            held_vld_r <= 1'b0;
        end else if (emit_s) begin
            if (pressed_s && held_vld_r && (held_r == {ext_s, shift_r})) begin
                held_vld_r <= 1'b1;
            end else begin
                ps2_key <= {~ps2_key[10], pressed_s, ext_s, shift_r};
                if (pressed_s) begin
                    held_r     <= {ext_s, shift_r};
                    held_vld_r <= 1'b1;
                end else begin
                    held_vld_r <= 1'b0;
                end
            end
        end else begin
            held_vld_r <= held_vld_r;
        end
    end
`else
    // Publish every decoded make and break.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            ps2_key <= 11'd0;
        end else if (emit_s) begin
            ps2_key <= {~ps2_key[10], pressed_s, ext_s, shift_r};
        end else begin
            ps2_key <= ps2_key;
        end
    end
`endif

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Directed scoreboard bench for ps2_key_encoder: expected events are queued as bytes are sent
// and checked by a monitor that watches ps2_key[10] toggles.
module tb_ps2_key_encoder;

    localparam int TMO  = 2000;
    localparam int HALF = 40;

    logic        clk_sys  = 1'b0;
    logic        RESET    = 1'b1;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        parity_err;
    logic        frame_err;

    int          n_cmp    = 0;
    int          n_err    = 0;
    logic [9:0]  exp_q[$];
    int          exp_tog  = 0;
    int          toggles  = 0;
    int          perr_cnt = 0;
    int          ferr_cnt = 0;
    bit          mon_en   = 1'b0;
    logic        prev_b10 = 1'b0;
    logic        prev_pe  = 1'b0;
    logic        prev_fe  = 1'b0;

    always #5 clk_sys = ~clk_sys;

    ps2_key_encoder #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO)) dut (
        .clk_sys    (clk_sys),
        .RESET      (RESET),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .ps2_key    (ps2_key),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    // Monitor: pop and compare on every toggle, count error pulses and check they last one cycle.
    always @(negedge clk_sys) begin
        logic [9:0] e;
        if (mon_en) begin
            if (ps2_key[10] !== prev_b10) begin
                toggles++;
                n_cmp++;
                assert (exp_q.size() > 0) else begin
                    n_err++;
                    $error("FAIL unexpected_event: observed key %h, expected no event", ps2_key);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    assert (ps2_key[9:0] === e) else begin
                        n_err++;
                        $error("FAIL event: observed %h expected %h", ps2_key[9:0], e);
                    end
                end
            end
            if (parity_err) begin
                if (!prev_pe) perr_cnt++;
                n_cmp++;
                assert (prev_pe === 1'b0) else begin
                    n_err++;
                    $error("FAIL parity_err_width: observed high 2 cycles, expected 1");
                end
            end
            if (frame_err) begin
                if (!prev_fe) ferr_cnt++;
                n_cmp++;
                assert (prev_fe === 1'b0) else begin
                    n_err++;
                    $error("FAIL frame_err_width: observed high 2 cycles, expected 1");
                end
            end
        end
        prev_b10 = ps2_key[10];
        prev_pe  = parity_err;
        prev_fe  = frame_err;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [9:0] v);
        exp_q.push_back(v);
        exp_tog++;
    endtask

    // Drives the first nbits of a frame; data returns high afterwards.
    task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic stop, input int nbits);
        logic [10:0] f;
        f = {stop, (~^b) ^ flip_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            cyc(HALF);
            ps2_clk = 1'b0;
            cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1, 11);
        cyc(4 * HALF);
    endtask

    initial begin
        cyc(5);
        RESET = 1'b0;
        cyc(3);
        chk("reset_key", 32'(ps2_key), 32'h0);
        chk("reset_perr", 32'(parity_err), 32'h0);
        chk("reset_ferr", 32'(frame_err), 32'h0);
        mon_en = 1'b1;

        // Single make 29, with a latency check around the stop-bit edge.
        push(10'h229);
        send_frame(8'h29, 1'b0, 1'b1, 10);
        cyc(HALF);
        ps2_clk = 1'b0;
        cyc(5);
        chk("key_not_yet", 32'(ps2_key), 32'h0);
        cyc(HALF);
        ps2_clk = 1'b1;
        chk("key_29", 32'(ps2_key), 32'h629);
        cyc(4 * HALF);
        chk("q_29", 32'(exp_q.size()), 32'd0);

        // Break 29.
        push(10'h029);
        send(8'hF0);
        send(8'h29);
        chk("q_f029", 32'(exp_q.size()), 32'd0);
        chk("key_f029", 32'(ps2_key), 32'h029);

        // Extended make and break.
        push(10'h375);
        push(10'h175);
        send(8'hE0);
        send(8'h75);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        chk("q_e075", 32'(exp_q.size()), 32'd0);
        chk("tog_e075", 32'(toggles), 32'(exp_tog));

        // Parity error frame, then the good one.
        send_frame(8'h1C, 1'b1, 1'b1, 11);
        cyc(4 * HALF);
        chk("perr_cnt", 32'(perr_cnt), 32'd1);
        chk("key_after_perr", 32'(ps2_key[9:0]), 32'h175);
        push(10'h21C);
        send(8'h1C);
        chk("q_1c", 32'(exp_q.size()), 32'd0);

        // Partial frame aborted by timeout.
        send_frame(8'h5A, 1'b0, 1'b1, 4);
        cyc(TMO + 10);
        chk("ferr_timeout", 32'(ferr_cnt), 32'd1);
        push(10'h214);
        send(8'h14);
        chk("q_14", 32'(exp_q.size()), 32'd0);

        // Pause sequence swallowed, then three 1A makes.
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        chk("tog_pause", 32'(toggles), 32'(exp_tog));
`ifdef PS2_KEY_TYPEMATIC_FILTER_EN
        push(10'h21A);
`else
        push(10'h21A);
        push(10'h21A);
        push(10'h21A);
`endif
        send(8'h1A); send(8'h1A); send(8'h1A);
        chk("q_1a", 32'(exp_q.size()), 32'd0);
        chk("tog_1a", 32'(toggles), 32'(exp_tog));

        // Bad stop bit.
        send_frame(8'h33, 1'b0, 1'b0, 11);
        cyc(4 * HALF);
        chk("ferr_stop", 32'(ferr_cnt), 32'd2);

        // Short clock glitch with data low must not become a start bit.
        ps2_data = 1'b0;
        cyc(20);
        ps2_clk = 1'b0;
        cyc(3);
        ps2_clk = 1'b1;
        cyc(20);
        ps2_data = 1'b1;
        cyc(100);
        chk("ferr_glitch", 32'(ferr_cnt), 32'd2);

        // Discarded AA cancels the E0 prefix.
        push(10'h229);
        send(8'hE0);
        send(8'hAA);
        send(8'h29);
        chk("q_aa", 32'(exp_q.size()), 32'd0);

        // Reset mid-frame clears prefix state and the partial frame.
        send(8'hE0);
        mon_en = 1'b0;
        send_frame(8'h55, 1'b0, 1'b1, 5);
        RESET = 1'b1;
        cyc(3);
        RESET = 1'b0;
        cyc(3);
        chk("key_midreset", 32'(ps2_key), 32'h0);
        mon_en = 1'b1;
        push(10'h229);
        send(8'h29);
        chk("key_after_reset", 32'(ps2_key), 32'h629);
        chk("q_final", 32'(exp_q.size()), 32'd0);
        chk("tog_final", 32'(toggles), 32'(exp_tog));
        chk("perr_final", 32'(perr_cnt), 32'd1);
        chk("ferr_final", 32'(ferr_cnt), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
